// File: rtl/csr_commit_pkg.sv
// Shared definitions for the CSR/exception commit queue.
// An entry is {kind, addr, data}, packed MSB first, so kind is the top bit.
package csr_commit_pkg;

  localparam logic KIND_CSR = 1'b0;
  localparam logic KIND_EXC = 1'b1;

  localparam int CSR_AW  = 32;
  localparam int CSR_DW  = 32;
  localparam int ENTRY_W = 1 + CSR_AW + CSR_DW;

  typedef struct packed {
    logic              kind;
    logic [CSR_AW-1:0] addr;
    logic [CSR_DW-1:0] data;
  } entry_t;

endpackage

// File: rtl/csr_commit_fifo.sv
// Circular buffer with two write slots per cycle and one read port.
// Slot 1 is written at wr_ptr+1. It is only used when slot 0 is also written.
// Entry storage is not reset. Only the pointers and the count are reset.
module csr_commit_fifo #(
  parameter int DEPTH = 8,
  parameter int EW    = 65
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_we0,
  input  logic [EW-1:0]          i_d0,
  input  logic                   i_we1,
  input  logic [EW-1:0]          i_d1,
  input  logic                   i_re,
  output logic [EW-1:0]          o_rdata,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_wr_ptr1;
  logic [1:0]    w_n_enq;

  assign w_wr_ptr1 = r_wr_ptr + PW'(1);
  assign w_n_enq   = 2'(i_we0) + 2'(i_we1);
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage writes: slot 0 at wr_ptr, slot 1 at the next (wrapping) location.
  always_ff @(posedge clock) begin
    if (i_we0) r_mem[r_wr_ptr]  <= i_d0;
    if (i_we1) r_mem[w_wr_ptr1] <= i_d1;
  end

  // Pointer and occupancy bookkeeping. Enqueue and dequeue can occur in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_n_enq);
      if (i_re) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count  <= r_count + CW'(w_n_enq) - CW'(i_re);
    end
  end

endmodule

// File: rtl/csr_commit_queue.sv
// Writeback-side CSR/exception commit queue.
// Retiring CSR writes and exceptions are buffered in program order.
// The buffered entries are offered to the sink one per cycle over valid/ready.
// Optional feature macro: CSR_COMMIT_STATS_EN. When it is defined, the module
// adds saturating counters for dequeued CSR entries, dequeued exception
// entries and stalled cycles.
module csr_commit_queue
  import csr_commit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wb_valid,
  input  logic          csr_wen,
  input  logic [AW-1:0] csr_waddr,
  input  logic [DW-1:0] csr_wdata,
  input  logic          exception_wen,
  input  logic [AW-1:0] mcause_in,
  input  logic [DW-1:0] pc_wb,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_kind,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
`ifdef CSR_COMMIT_STATS_EN
  output logic [31:0]   stat_csr_cnt,
  output logic [31:0]   stat_exc_cnt,
  output logic [31:0]   stat_stall_cnt,
`endif
  output logic          empty
);

  localparam int EW = 1 + AW + DW;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [EW-1:0] w_csr_entry;
  logic [EW-1:0] w_exc_entry;
  logic [EW-1:0] w_d0;
  logic [EW-1:0] w_head;
  logic          w_accept;
  logic          w_we0;
  logic          w_we1;
  logic          w_deq;
  logic [CW-1:0] w_count;

  assign w_csr_entry = {KIND_CSR, csr_waddr, csr_wdata};
  assign w_exc_entry = {KIND_EXC, mcause_in, pc_wb};

  // A dual event needs two free slots. Therefore in_ready reserves two slots.
  // in_ready depends only on the registered count.
  assign in_ready = (w_count <= CW'(DEPTH - 2));
  assign w_accept = wb_valid & in_ready;

  // Slot 0 takes the CSR entry if there is one, otherwise the exception entry.
  // Slot 1 is used only by the exception half of a dual event.
  assign w_we0 = w_accept & (csr_wen | exception_wen);
  assign w_we1 = w_accept & csr_wen & exception_wen;
  assign w_d0  = csr_wen ? w_csr_entry : w_exc_entry;

  assign out_valid = (w_count != '0);
  assign empty     = ~out_valid;
  assign w_deq     = out_valid & out_ready;

  // The head is masked while the queue is empty.
  // This keeps out_* at zero without resetting the storage.
  assign out_kind = out_valid ? w_head[EW-1]        : 1'b0;
  assign out_addr = out_valid ? w_head[EW-2 -: AW]  : '0;
  assign out_data = out_valid ? w_head[DW-1:0]      : '0;

  csr_commit_fifo #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_we0   (w_we0),
    .i_d0    (w_d0),
    .i_we1   (w_we1),
    .i_d1    (w_exc_entry),
    .i_re    (w_deq),
    .o_rdata (w_head),
    .o_count (w_count)
  );

`ifdef CSR_COMMIT_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_csr_cnt;
  logic [31:0] r_exc_cnt;
  logic [31:0] r_stall_cnt;

  // Saturating counters for dequeued entries by kind and for sink stall cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_csr_cnt   <= '0;
      r_exc_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_deq && out_kind == KIND_CSR) r_csr_cnt <= sat_inc(r_csr_cnt);
      if (w_deq && out_kind == KIND_EXC) r_exc_cnt <= sat_inc(r_exc_cnt);
      if (out_valid && !out_ready)       r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign stat_csr_cnt   = r_csr_cnt;
  assign stat_exc_cnt   = r_exc_cnt;
  assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_csr_commit_queue.sv
// Directed bench for csr_commit_queue (DEPTH=8, AW=DW=32).
// Define CSR_COMMIT_STATS_EN to also check the statistics counters.
module tb_csr_commit_queue;

  logic        clock;
  logic        reset;
  logic        wb_valid;
  logic        csr_wen;
  logic [31:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        exception_wen;
  logic [31:0] mcause_in;
  logic [31:0] pc_wb;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        out_kind;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        empty;
`ifdef CSR_COMMIT_STATS_EN
  logic [31:0] stat_csr_cnt;
  logic [31:0] stat_exc_cnt;
  logic [31:0] stat_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  csr_commit_queue #(.DEPTH(8), .AW(32), .DW(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .csr_wen       (csr_wen),
    .csr_waddr     (csr_waddr),
    .csr_wdata     (csr_wdata),
    .exception_wen (exception_wen),
    .mcause_in     (mcause_in),
    .pc_wb         (pc_wb),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_kind      (out_kind),
    .out_addr      (out_addr),
    .out_data      (out_data),
`ifdef CSR_COMMIT_STATS_EN
    .stat_csr_cnt  (stat_csr_cnt),
    .stat_exc_cnt  (stat_exc_cnt),
    .stat_stall_cnt(stat_stall_cnt),
`endif
    .empty         (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic k, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_kind"},  64'(out_kind),  64'(k));
    chk({tag, "_addr"},  64'(out_addr),  64'(a));
    chk({tag, "_data"},  64'(out_data),  64'(d));
  endtask

  task automatic set_csr(input logic [31:0] a, input logic [31:0] d);
    wb_valid = 1'b1; csr_wen = 1'b1; csr_waddr = a; csr_wdata = d;
  endtask

  task automatic idle();
    wb_valid = 1'b0; csr_wen = 1'b0; exception_wen = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; out_ready = 1'b1;
    wb_valid = 1'b0; csr_wen = 1'b0; exception_wen = 1'b0;
    csr_waddr = '0; csr_wdata = '0; mcause_in = '0; pc_wb = '0;

    // reset held for 3 cycles
    repeat (3) tick();
    chk("rst_empty",    64'(empty),     64'd1);
    chk("rst_valid",    64'(out_valid), 64'd0);
    chk("rst_inready",  64'(in_ready),  64'd1);
    chk("rst_addr",     64'(out_addr),  64'd0);
    reset = 1'b1;
    tick();
    chk("post_rst_empty",   64'(empty),    64'd1);
    chk("post_rst_inready", 64'(in_ready), 64'd1);

    // single CSR write, 1-cycle latency
    set_csr(32'h300, 32'h1800);
    tick();
    idle();
    chk_head("single", 1'b0, 32'h300, 32'h1800);
    chk("single_empty", 64'(empty), 64'd0);
    tick();
    chk("single_drained", 64'(empty), 64'd1);

    // wb_valid with neither write enable set writes nothing
    wb_valid = 1'b1;
    tick();
    idle();
    chk("noop_empty", 64'(empty), 64'd1);

    // dual event: CSR then EXC
    set_csr(32'h341, 32'h8000_0010);
    exception_wen = 1'b1; mcause_in = 32'hB; pc_wb = 32'h8000_0010;
    tick();
    idle();
    chk_head("dual0", 1'b0, 32'h341, 32'h8000_0010);
    tick();
    chk_head("dual1", 1'b1, 32'hB, 32'h8000_0010);
    tick();
    chk("dual_empty", 64'(empty), 64'd1);

    // back-pressure: 7 writes with the sink stalled
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("bp_inready_hi", 64'(in_ready), 64'd1);
      set_csr(32'h100 + 32'(i), 32'(i));
      tick();
    end
    idle();
    chk("bp_inready_lo", 64'(in_ready), 64'd0);
    chk_head("bp_head0", 1'b0, 32'h100, 32'd0);
    // protocol error: this input must be ignored
    set_csr(32'hDEAD, 32'hDEAD);
    tick();
    idle();
    chk("bp_ignored_inready", 64'(in_ready), 64'd0);
    chk_head("bp_head0_stable", 1'b0, 32'h100, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_inready_back", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 1; i < 7; i++) begin
      chk_head("bp_order", 1'b0, 32'h100 + 32'(i), 32'(i));
      tick();
    end
    chk("bp_empty", 64'(empty), 64'd1);

    // the pointers are now at 2; stream 5 entries to move them to 7
    for (int i = 0; i < 5; i++) begin
      set_csr(32'h200 + 32'(i), 32'h5000 + 32'(i));
      tick();
    end
    idle();
    chk_head("stream_last", 1'b0, 32'h204, 32'h5004);
    tick();
    chk("stream_empty", 64'(empty), 64'd1);

    // dual event across the wrap (slots 7 and 0)
    out_ready = 1'b0;
    set_csr(32'h305, 32'hAAAA_5555);
    exception_wen = 1'b1; mcause_in = 32'h2; pc_wb = 32'h1234_5678;
    tick();
    idle();
    chk_head("wrap0", 1'b0, 32'h305, 32'hAAAA_5555);
    tick();
    chk_head("wrap0_stable", 1'b0, 32'h305, 32'hAAAA_5555);
    out_ready = 1'b1;
    tick();
    chk_head("wrap1", 1'b1, 32'h2, 32'h1234_5678);
    tick();
    chk("wrap_empty", 64'(empty), 64'd1);

    // asynchronous reset while the queue is half full
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_csr(32'h400 + 32'(i), 32'(i));
      tick();
    end
    idle();
    chk("mid_nonempty", 64'(empty), 64'd0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_empty",   64'(empty),     64'd1);
    chk("mid_rst_valid",   64'(out_valid), 64'd0);
    chk("mid_rst_inready", 64'(in_ready),  64'd1);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_after_empty", 64'(empty), 64'd1);

`ifdef CSR_COMMIT_STATS_EN
    chk("stat_rst_csr",   64'(stat_csr_cnt),   64'd0);
    chk("stat_rst_stall", 64'(stat_stall_cnt), 64'd0);
    // 3 CSR + 2 EXC entries; the sink stalls for 4 cycles
    out_ready = 1'b0;
    set_csr(32'h10, 32'h1);
    tick();
    set_csr(32'h11, 32'h2);
    exception_wen = 1'b1; mcause_in = 32'h3; pc_wb = 32'h3;
    tick();
    exception_wen = 1'b0;
    set_csr(32'h12, 32'h4);
    tick();
    csr_wen = 1'b0; exception_wen = 1'b1; mcause_in = 32'h5; pc_wb = 32'h5;
    tick();
    idle();
    tick();
    out_ready = 1'b1;
    repeat (5) tick();
    out_ready = 1'b0;
    tick();
    chk("stat_empty", 64'(empty),          64'd1);
    chk("stat_csr",   64'(stat_csr_cnt),   64'd3);
    chk("stat_exc",   64'(stat_exc_cnt),   64'd2);
    chk("stat_stall", 64'(stat_stall_cnt), 64'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_commit_queue.md
Name: csr_commit_queue

Overview:
- Producer side of the CSR/exception commit channel. Sits at the writeback stage.
- Captures CSR writes and exception events from retiring instructions and buffers them in a FIFO.
- Presents buffered events one per cycle, in program order, to the downstream commit/difftest sink over a valid/ready handshake.
- Decouples the sink's acceptance rate from WB retirement; back-pressures WB when the FIFO is nearly full.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, >= 4.
- AW, 32, width of the CSR address/mcause field.
- DW, 32, width of the CSR data/pc field.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- wb_valid  in  1  WB stage retires an instruction this cycle.
- csr_wen  in  1  the retiring instruction writes a CSR.
- csr_waddr  in  AW  CSR address.
- csr_wdata  in  DW  CSR write data.
- exception_wen  in  1  the retiring instruction raises an exception/trap.
- mcause_in  in  AW  trap cause.
- pc_wb  in  DW  pc of the retiring instruction.
- in_ready  out  1  queue can accept a full WB event this cycle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  sink accepts the head entry.
- out_kind  out  1  0 = CSR write, 1 = exception.
- out_addr  out  AW  csr_waddr or mcause.
- out_data  out  DW  csr_wdata or pc.
- empty  out  1  FIFO holds no entries.

Behaviour:
- Reset (reset=0, async): rd_ptr=wr_ptr=0, count=0, out_valid=0, out_kind=0, out_addr=0, out_data=0, empty=1, in_ready=1. Reset mid-operation discards all buffered entries; there is no partial-drain behaviour.
- Accept condition: accept = wb_valid & in_ready.
- in_ready = (DEPTH - count) >= 2. It is registered-state-only, with no combinational path from wb_valid or out_ready.
- Enqueue on accept:
  - csr_wen only: 1 entry {0, csr_waddr, csr_wdata}.
  - exception_wen only: 1 entry {1, mcause_in, pc_wb}.
  - Both set: 2 entries in one cycle, CSR entry first at wr_ptr, exception entry at wr_ptr+1.
  - Neither set: no entry is written.
  - wb_valid=1 while in_ready=0 is a protocol error. WB must hold; the queue ignores the input.
- Dequeue: when out_valid & out_ready, rd_ptr advances by 1.
- out_* are driven from the head entry (storage read at rd_ptr). out_valid = (count != 0). While out_valid=1 and out_ready=0, out_* stay stable.
- Latency: an entry written at edge N is visible on out_* after edge N, i.e. 1 cycle. There is no same-cycle bypass.
- Simultaneous events: enqueue of 1 or 2 entries and dequeue of 1 entry in the same cycle. Next count = count + n_enq - deq.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. A double write spanning the wrap (wr_ptr=DEPTH-1) lands at DEPTH-1 and 0.
- count is log2(DEPTH)+1 bits and never exceeds DEPTH, guaranteed by the in_ready rule.
- empty = (count == 0).

Optional Feature:
- Macro: CSR_COMMIT_STATS_EN.
- Defined:
  - Adds outputs stat_csr_cnt[31:0], stat_exc_cnt[31:0] and stat_stall_cnt[31:0].
  - stat_csr_cnt and stat_exc_cnt count dequeued entries by kind.
  - stat_stall_cnt counts cycles with out_valid & ~out_ready.
  - All three saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package csr_commit_pkg:
  - kind constants KIND_CSR=1'b0, KIND_EXC=1'b1.
  - entry typedef {kind, addr[AW], data[DW]}, with its width constant ENTRY_W = 1+AW+DW.
- Sub-module csr_commit_fifo:
  - Generic DEPTH x ENTRY_W storage with 2 write ports (slot0 at wr_ptr, slot1 at wr_ptr+1) and 1 read port.
  - Also holds the pointers and count.
- The top level holds the enqueue encoding, in_ready and the optional stats.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release → out_valid=0, empty=1, in_ready=1. Assert reset during a half-full queue → empty=1 immediately (async).
- Single CSR write: wb_valid=1, csr_wen=1, csr_waddr=0x300, csr_wdata=0x1800, out_ready=1 → next cycle out_valid=1, kind=0, addr=0x300, data=0x1800; empty=1 the cycle after.
- Dual event: csr_wen=1 (0x341, 0x80000010) and exception_wen=1 (mcause=0xB, pc=0x80000010) in one cycle → two consecutive heads: {0,0x341,0x80000010} then {1,0xB,0x80000010}.
- Back-pressure, DEPTH=8: out_ready=0, 7 single CSR writes → in_ready drops to 0 at count=7. One dequeue → in_ready=1. Order is preserved over all 7.
- Wrap: fill and drain to put wr_ptr at 7, then issue a dual event → entries at slots 7 and 0, dequeued CSR then EXC with correct values.
- Stats (CSR_COMMIT_STATS_EN): 3 CSR + 2 EXC dequeued, 4 stalled cycles → stat_csr_cnt=3, stat_exc_cnt=2, stat_stall_cnt=4.
